// File: rtl/jtag_shift_ctrl_pkg.sv
// rtl/jtag_shift_ctrl_pkg.sv - shared types and TAP walk constants for the JTAG shift sequencer
package jtag_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_RESET    = 2'd0,
        CMD_SHIFT_IR = 2'd1,
        CMD_SHIFT_DR = 2'd2,
        CMD_IDLE     = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_SEL,
        ST_SHIFT,
        ST_EXIT,
        ST_RUNTEST,
        ST_RSP
    } state_e;

    localparam int RST_TMS_ONES = 5;
    localparam int SEL_DR_LEN   = 3;
    localparam int SEL_IR_LEN   = 4;
    localparam int EXIT_LEN     = 2;

    // Index of the final TCK in a walk state; len encodes N with 0 meaning 32,
    // so len-1 wraps to 31 for the 32-bit case.
    function automatic logic [4:0] last_tck(state_e st, cmd_type_e ty, logic [4:0] len);
        case (st)
            ST_RST:  return 5'(RST_TMS_ONES);
            ST_SEL:  return (ty == CMD_SHIFT_IR) ? 5'(SEL_IR_LEN - 1) : 5'(SEL_DR_LEN - 1);
            ST_EXIT: return 5'(EXIT_LEN - 1);
            default: return len - 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK phase counter producing tck and fall/rise strobes
module jtag_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run,
    output logic tck_o,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int PERIOD = 2 * TCK_DIV;
    localparam int CW     = $clog2(PERIOD);

    logic [CW-1:0] cnt;

    assign fall_stb = run && (cnt == '0);
    assign rise_stb = run && (cnt == CW'(TCK_DIV));

    // Phase counter: held at zero while idle so the first low phase starts right after run rises
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt == CW'(PERIOD - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // TCK level: rises on rise_stb, falls on fall_stb, rests low when stopped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_o <= 1'b0;
        end else if (!run) begin
            tck_o <= 1'b0;
        end else if (rise_stb) begin
            tck_o <= 1'b1;
        end else if (fall_stb) begin
            tck_o <= 1'b0;
        end
    end

endmodule

// File: rtl/jtag_shift_ctrl.sv
// rtl/jtag_shift_ctrl.sv - JTAG TAP command sequencer (optional TRST pulse: JTAG_SHIFT_CTRL_TRST_EN)
module jtag_shift_ctrl
    import jtag_shift_ctrl_pkg::*;
#(
    parameter int TCK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_type_i,
    input  logic [4:0]  cmd_len_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        busy_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    output logic        trst_n_o,
    input  logic        tdo_i
);

    state_e      state, state_d;
    logic [4:0]  idx, idx_d;
    logic        tck_active, active_d;

    cmd_type_e   type_q;
    logic [4:0]  len_q;
    logic [31:0] data_q;
    logic [31:0] cap, cap_next;
    logic        tms_q, tdi_q;

    logic        run, fall_stb, rise_stb;
    logic        issue, tms_val, tdi_val;

    assign run = (state != ST_IDLE) && (state != ST_RSP);

    jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .run      (run),
        .tck_o    (tck_o),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    // State register: state, TCK index within the state, and whether a TCK of it is in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            idx        <= '0;
            tck_active <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            tck_active <= active_d;
        end
    end

    // Next state: on each low-phase start retire the in-flight TCK and pick the next one
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        active_d = tck_active;
        case (state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    idx_d    = '0;
                    active_d = 1'b0;
                    case (cmd_type_e'(cmd_type_i))
                        CMD_RESET: state_d = ST_RST;
                        CMD_IDLE:  state_d = ST_RUNTEST;
                        default:   state_d = ST_SEL;
                    endcase
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (fall_stb) begin
                    if (tck_active) begin
                        if (idx == last_tck(state, type_q, len_q)) begin
                            idx_d = '0;
                            case (state)
                                ST_SEL:   state_d = ST_SHIFT;
                                ST_SHIFT: state_d = ST_EXIT;
                                default:  state_d = ST_RSP;
                            endcase
                        end else begin
                            idx_d = idx + 5'd1;
                        end
                    end
                    active_d = (state_d != ST_RSP);
                end
            end
        endcase
    end

    // Outputs: handshake flags and the TMS/TDI values for the TCK about to be issued
    always_comb begin
        cmd_ready_o = (state == ST_IDLE);
        rsp_valid_o = (state == ST_RSP);
        busy_o      = (state != ST_IDLE);
        issue       = fall_stb && (state_d != ST_RSP);
        tms_val     = 1'b0;
        tdi_val     = 1'b0;
        case (state_d)
            ST_RST:   tms_val = (idx_d < 5'(RST_TMS_ONES));
            ST_SEL:   tms_val = (type_q == CMD_SHIFT_IR) ? (idx_d < 5'd2) : (idx_d == 5'd0);
            ST_SHIFT: begin
                tms_val = (idx_d == len_q - 5'd1);
                tdi_val = data_q[idx_d];
            end
            ST_EXIT:  tms_val = (idx_d == 5'd0);
            default:  tms_val = 1'b0;
        endcase
    end

    // Capture shifts right with the new TDO bit entering at N-1, so bits >= N stay zero
    always_comb begin
        cap_next = cap >> 1;
        cap_next[len_q - 5'd1] = tdo_i;
    end

    // Datapath: latch command on accept, drive TMS/TDI per TCK, sample TDO on TCK rise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            type_q <= CMD_RESET;
            len_q  <= '0;
            data_q <= '0;
            cap    <= '0;
            tms_q  <= 1'b1;
            tdi_q  <= 1'b0;
        end else begin
            if (cmd_ready_o && cmd_valid_i) begin
                type_q <= cmd_type_e'(cmd_type_i);
                len_q  <= cmd_len_i;
                data_q <= cmd_data_i;
                cap    <= '0;
            end
            if (issue) begin
                tms_q <= tms_val;
                tdi_q <= tdi_val;
            end
            if (rise_stb && (state == ST_SHIFT)) begin
                cap <= cap_next;
            end
        end
    end

    assign tms_o      = tms_q;
    assign tdi_o      = tdi_q;
    assign rsp_data_o = cap;

`ifdef JTAG_SHIFT_CTRL_TRST_EN
    logic trst_q;

    // TRST low for exactly the first TCK period of a RESET walk
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trst_q <= 1'b1;
        end else if (fall_stb) begin
            trst_q <= !(issue && (state_d == ST_RST) && (idx_d == 5'd0));
        end
    end

    assign trst_n_o = trst_q;
`else
    assign trst_n_o = 1'b1;
`endif

endmodule

// File: tb/tb_jtag_shift_ctrl.sv
// tb/tb_jtag_shift_ctrl.sv - directed self-checking bench for jtag_shift_ctrl with a TAP model
module tb_jtag_shift_ctrl;

    localparam int          TCK_DIV = 2;
    localparam logic [31:0] IDCODE  = 32'h2495_11C3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_type_i = 2'd0;
    logic [4:0]  cmd_len_i = 5'd0;
    logic [31:0] cmd_data_i = 32'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        busy_o;
    logic        tck_o, tms_o, tdi_o, trst_n_o;
    logic        tdo_i;
    logic        loop_en = 1'b0;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk_i = ~clk_i;

    jtag_shift_ctrl #(
        .TCK_DIV (TCK_DIV)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_type_i  (cmd_type_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_data_i  (cmd_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o),
        .tck_o       (tck_o),
        .tms_o       (tms_o),
        .tdi_o       (tdi_o),
        .trst_n_o    (trst_n_o),
        .tdo_i       (tdo_i)
    );

    // TMS log indexed by absolute TCK count
    int            tck_cnt = 0;
    logic [1023:0] tms_log = '0;

    always @(posedge tck_o) begin
        tms_log[tck_cnt[9:0]] <= tms_o;
        tck_cnt <= tck_cnt + 1;
    end

    // TAP model: IR 0x11 selects the IDCODE data register
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_e;
    tap_e        tap_st = TLR;
    logic [4:0]  tap_ir = 5'h01;
    logic [4:0]  ir_sh = 5'h0;
    logic [31:0] dr_sh = 32'h0;
    logic        tap_tdo = 1'b0;

    always @(posedge tck_o or negedge trst_n_o) begin
        if (!trst_n_o) begin
            tap_st <= TLR;
            tap_ir <= 5'h01;
        end else begin
            case (tap_st)
                TLR:   begin tap_st <= tms_o ? TLR : RTI; tap_ir <= 5'h01; end
                RTI:   tap_st <= tms_o ? SELDR : RTI;
                SELDR: tap_st <= tms_o ? SELIR : CAPDR;
                CAPDR: begin tap_st <= tms_o ? EX1DR : SHDR; dr_sh <= (tap_ir == 5'h11) ? IDCODE : 32'h0; end
                SHDR:  begin tap_st <= tms_o ? EX1DR : SHDR; dr_sh <= {tdi_o, dr_sh[31:1]}; end
                EX1DR: tap_st <= tms_o ? UPDR : PDR;
                PDR:   tap_st <= tms_o ? EX2DR : PDR;
                EX2DR: tap_st <= tms_o ? UPDR : SHDR;
                UPDR:  tap_st <= tms_o ? SELDR : RTI;
                SELIR: tap_st <= tms_o ? TLR : CAPIR;
                CAPIR: begin tap_st <= tms_o ? EX1IR : SHIR; ir_sh <= 5'b00001; end
                SHIR:  begin tap_st <= tms_o ? EX1IR : SHIR; ir_sh <= {tdi_o, ir_sh[4:1]}; end
                EX1IR: tap_st <= tms_o ? UPIR : PIR;
                PIR:   tap_st <= tms_o ? EX2IR : PIR;
                EX2IR: tap_st <= tms_o ? UPIR : SHIR;
                UPIR:  begin tap_st <= tms_o ? SELDR : RTI; tap_ir <= ir_sh; end
                default: tap_st <= TLR;
            endcase
        end
    end

    always @(negedge tck_o) begin
        tap_tdo <= (tap_st == SHDR) ? dr_sh[0] : ((tap_st == SHIR) ? ir_sh[0] : 1'b0);
    end

    assign tdo_i = loop_en ? tdi_o : tap_tdo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    int          lat, ntck, trst_lo, trst_first;
    logic [31:0] rdata;
    logic [63:0] tseq;

    // Issue one command and wait (bounded) for rsp_valid_o; edge 0 is the accept edge
    task automatic send(input logic [1:0] ty, input logic [4:0] len, input logic [31:0] data);
        int base;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_type_i  = ty;
        cmd_len_i   = len;
        cmd_data_i  = data;
        base        = tck_cnt;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        lat = 0;
        trst_lo = 0;
        trst_first = 0;
        while (rsp_valid_o !== 1'b1 && lat < 2000) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (trst_n_o === 1'b0) begin
                trst_lo++;
                if (trst_first == 0) trst_first = lat;
            end
        end
        rdata = rsp_data_o;
        ntck  = tck_cnt - base;
        tseq  = 64'(tms_log >> base);
        if (ntck < 64) tseq = tseq & ((64'd1 << ntck) - 64'd1);
    endtask

    task automatic consume(input string tag);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        check({tag, "_rsp_drop"}, 64'(rsp_valid_o), 64'd0);
        check({tag, "_ready_up"}, 64'(cmd_ready_o), 64'd1);
    endtask

    int bp_bad;
    int bp_base;

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_data",  64'(rsp_data_o),  64'd0);
        check("rst_busy",      64'(busy_o),      64'd0);
        check("rst_tck",       64'(tck_o),       64'd0);
        check("rst_tms",       64'(tms_o),       64'd1);
        check("rst_tdi",       64'(tdi_o),       64'd0);
        check("rst_trst",      64'(trst_n_o),    64'd1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // RESET: 6 TCKs, TMS 1,1,1,1,1,0, response at 1+6*4
        send(2'd0, 5'd0, 32'hFFFF_FFFF);
        check("reset_lat",  64'(lat),  64'd25);
        check("reset_ntck", 64'(ntck), 64'd6);
        check("reset_tms",  tseq,      64'h1F);
        check("reset_data", 64'(rdata), 64'd0);
        check("reset_tap_rti", 64'(tap_st == RTI), 64'd1);
`ifdef JTAG_SHIFT_CTRL_TRST_EN
        check("reset_trst_lo",    64'(trst_lo),    64'd4);
        check("reset_trst_first", 64'(trst_first), 64'd1);
`else
        check("reset_trst_lo", 64'(trst_lo), 64'd0);
`endif
        consume("reset");

        // SHIFT_IR N=5 0x11: TMS 1,1,0,0,0,0,0,0,1,1,0; captured IR = 0b00001
        send(2'd1, 5'd5, 32'h11);
        check("ir_lat",    64'(lat),   64'd45);
        check("ir_ntck",   64'(ntck),  64'd11);
        check("ir_tms",    tseq,       64'h303);
        check("ir_data",   64'(rdata), 64'h01);
        check("ir_loaded", 64'(tap_ir), 64'h11);
        consume("ir");

        // SHIFT_DR 32 bits reads the model IDCODE
        send(2'd2, 5'd0, 32'h0);
        check("idcode_lat",  64'(lat),   64'd149);
        check("idcode_tms",  tseq,       64'hC_0000_0001);
        check("idcode_data", 64'(rdata), 64'(IDCODE));
        consume("idcode");

        loop_en = 1'b1;

        // Loopback DR N=8 0xA5: 13 TCKs, response at edge 53
        send(2'd2, 5'd8, 32'hA5);
        check("dr8_lat",  64'(lat),   64'd53);
        check("dr8_ntck", 64'(ntck),  64'd13);
        check("dr8_tms",  tseq,       64'hC01);
        check("dr8_data", 64'(rdata), 64'hA5);

        // Backpressure for 20 clocks with a command offered that must be ignored
        bp_bad  = 0;
        bp_base = tck_cnt;
        cmd_valid_i = 1'b1;
        cmd_type_i  = 2'd3;
        cmd_len_i   = 5'd4;
        repeat (20) begin
            @(posedge clk_i);
            #1;
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hA5 || cmd_ready_o !== 1'b0 || tck_o !== 1'b0)
                bp_bad++;
        end
        cmd_valid_i = 1'b0;
        check("bp_hold_bad", 64'(bp_bad), 64'd0);
        check("bp_no_tck",   64'(tck_cnt - bp_base), 64'd0);
        consume("bp");
        check("bp_not_busy", 64'(busy_o), 64'd0);

        // N=1 with all-ones data: only bit 0 captured
        send(2'd2, 5'd1, 32'hFFFF_FFFF);
        check("dr1_lat",  64'(lat),   64'd25);
        check("dr1_tms",  tseq,       64'h19);
        check("dr1_data", 64'(rdata), 64'h1);
        consume("dr1");

        // N=32 loopback keeps both ends of the word
        send(2'd2, 5'd0, 32'h8000_00F1);
        check("dr32_lat",  64'(lat),   64'd149);
        check("dr32_data", 64'(rdata), 64'h8000_00F1);
        consume("dr32");

        // IDLE N=3: 3 TCKs with TMS 0, data 0
        send(2'd3, 5'd3, 32'hFFFF_FFFF);
        check("idle_lat",  64'(lat),   64'd13);
        check("idle_ntck", 64'(ntck),  64'd3);
        check("idle_tms",  tseq,       64'd0);
        check("idle_data", 64'(rdata), 64'd0);
        consume("idle");

        // Reset during the SHIFT state of a 32-bit DR shift, while TCK is high
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_type_i  = 2'd2;
        cmd_len_i   = 5'd0;
        cmd_data_i  = 32'hFFFF_FFFF;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        repeat (31) @(posedge clk_i);
        #1;
        check("mid_pre_tck",  64'(tck_o),  64'd1);
        check("mid_pre_tms",  64'(tms_o),  64'd0);
        check("mid_pre_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check("mid_tck",       64'(tck_o),       64'd0);
        check("mid_tms",       64'(tms_o),       64'd1);
        check("mid_tdi",       64'(tdi_o),       64'd0);
        check("mid_trst",      64'(trst_n_o),    64'd1);
        check("mid_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("mid_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("mid_rsp_data",  64'(rsp_data_o),  64'd0);
        check("mid_busy",      64'(busy_o),      64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        send(2'd0, 5'd0, 32'h0);
        check("rerst_lat",  64'(lat),   64'd25);
        check("rerst_tms",  tseq,       64'h1F);
        check("rerst_data", 64'(rdata), 64'd0);
        consume("rerst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
